pulse_queue_tx: RTL and testbench



---
 rtl/cdc_pkg.sv | 6 +
 rtl/sync_stages.sv | 15 +
 rtl/pulse_queue_tx.sv | 60 ++++++
 tb/tb_pulse_queue_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// cdc_pkg: state encoding and synchronizer depth limits shared by the pulse handshake blocks.
package cdc_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT_ACK = 1'b1} state_t;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
endpackage

// File: rtl/sync_stages.sv
// sync_stages: N-flop single-bit synchronizer with asynchronous active-high reset.
module sync_stages #(
  parameter int N = 2
) (
  input  logic aclk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] ff;
  always_ff @(posedge aclk_i or posedge arst_i)
    if (arst_i) ff <= '0;
    else ff <= {ff[N-2:0], d_i};
  assign q_o = ff[N-1];
endmodule

// File: rtl/pulse_queue_tx.sv
// pulse_queue_tx: queues source pulses and launches one request toggle per pulse, one in flight at a time.
// Define PULSE_TX_FAST_RELAUNCH_EN to relaunch on the acknowledge edge instead of passing through IDLE.
module pulse_queue_tx
  import cdc_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             aclk_i,
  input  logic             arst_i,
  input  logic             pulse_i,
  input  logic             ack_tgl_i,
  input  logic             clr_ovf_i,
  output logic             req_tgl_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             overflow_o
);
  // out-of-range depths are clamped rather than rejected
  localparam int STAGES = SYNC_STAGES < SYNC_MIN ? SYNC_MIN :
                          SYNC_STAGES > SYNC_MAX ? SYNC_MAX : SYNC_STAGES;
  state_t state;
  logic ack_s, ack_ok, launch, inc, drop;
  sync_stages #(.N(STAGES)) u_ack_sync (
    .aclk_i(aclk_i),
    .arst_i(arst_i),
    .d_i   (ack_tgl_i),
    .q_o   (ack_s)
  );
  assign ack_ok = ack_s == req_tgl_o;
`ifdef PULSE_TX_FAST_RELAUNCH_EN
  assign launch = |pending_o && (state == ST_IDLE || ack_ok);
`else
  assign launch = |pending_o && state == ST_IDLE;
`endif
  // a pulse at saturation is still accepted when a launch frees a slot
  assign inc  = pulse_i && (!(&pending_o) || launch);
  assign drop = pulse_i && &pending_o && !launch;
  always_ff @(posedge aclk_i or posedge arst_i)
    if (arst_i) begin
      pending_o  <= '0;
      overflow_o <= 1'b0;
    end else begin
      pending_o  <= pending_o + CNT_W'(inc) - CNT_W'(launch);
      overflow_o <= drop || (overflow_o && !clr_ovf_i);
    end
  always_ff @(posedge aclk_i or posedge arst_i)
    if (arst_i) begin
      state     <= ST_IDLE;
      req_tgl_o <= 1'b0;
      busy_o    <= 1'b0;
    end else if (launch) begin
      state     <= ST_WAIT_ACK;
      req_tgl_o <= ~req_tgl_o;
      busy_o    <= 1'b1;
    end else if (state == ST_WAIT_ACK && ack_ok) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
    end
endmodule

// File: tb/tb_pulse_queue_tx.sv
// tb_pulse_queue_tx: randomized and directed checks of pulse_queue_tx against an event-count reference model.
module tb_pulse_queue_tx;
  localparam int CNT_W = 2;
  localparam int N     = 2;
  localparam int MAX   = (1 << CNT_W) - 1;
`ifdef PULSE_TX_FAST_RELAUNCH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic aclk_i = 1'b0, arst_i = 1'b1, pulse_i = 1'b0, ack_tgl_i = 1'b0, clr_ovf_i = 1'b0;
  logic req_tgl_o, busy_o, overflow_o;
  logic [CNT_W-1:0] pending_o;
  int vecs = 0, miss = 0, dly = 0, m_pend = 0;
  bit hold = 1'b0, m_req = 1'b0, m_wait = 1'b0, m_ovf = 1'b0;
  bit ack_q[$], rq[$];
  pulse_queue_tx #(.CNT_W(CNT_W), .SYNC_STAGES(N)) dut (
    .aclk_i    (aclk_i),
    .arst_i    (arst_i),
    .pulse_i   (pulse_i),
    .ack_tgl_i (ack_tgl_i),
    .clr_ovf_i (clr_ovf_i),
    .req_tgl_o (req_tgl_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .overflow_o(overflow_o)
  );
  always #5 aclk_i = ~aclk_i;
  // ack value the destination toggle presents to the source logic at the coming edge
  function automatic bit next_acks();
    return ack_q.size() >= N ? ack_q[ack_q.size() - N] : 1'b0;
  endfunction
  function automatic bit will_launch(input bit acks);
    return m_pend > 0 && (!m_wait || (FAST && acks == m_req));
  endfunction
  task automatic check(input string name);
    vecs++;
    if ({req_tgl_o, busy_o, pending_o, overflow_o} !== {m_req, m_wait, CNT_W'(m_pend), m_ovf}) begin
      miss++;
      $display("FAIL %s t=%0t: req/busy/pend/ovf got %b/%b/%0d/%b expected %b/%b/%0d/%b", name, $time,
               req_tgl_o, busy_o, pending_o, overflow_o, m_req, m_wait, m_pend, m_ovf);
    end
  endtask
  task automatic cycle(input bit p, input bit clr, input string name);
    bit acks, ackd, l;
    pulse_i = p;
    clr_ovf_i = clr;
    acks = next_acks();
    ack_q.push_back(ack_tgl_i);
    ackd = m_wait && acks == m_req;
    l = will_launch(acks);
    if (p && m_pend == MAX && !l) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_pend = m_pend - int'(l) + int'(p && (m_pend < MAX || l));
    if (l) begin
      m_req = !m_req;
      m_wait = 1'b1;
    end else if (ackd) m_wait = 1'b0;
    @(posedge aclk_i);
    #1;
    check(name);
    rq.push_back(m_req);
    if (!hold) ack_tgl_i = rq.size() > dly ? rq[rq.size() - 1 - dly] : 1'b0;
  endtask
  task automatic model_reset();
    m_pend = 0; m_req = 1'b0; m_wait = 1'b0; m_ovf = 1'b0;
    ack_q.delete(); rq.delete();
    ack_tgl_i = 1'b0; hold = 1'b0; pulse_i = 1'b0; clr_ovf_i = 1'b0;
  endtask
  task automatic do_reset();
    arst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge aclk_i);
    #1;
    arst_i = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    check("reset");
    repeat (3) cycle(1'b0, 1'b0, "reset_idle");
  endtask
  task automatic test_single();
    dly = 5;
    cycle(1'b1, 1'b0, "single");
    repeat (20) cycle(1'b0, 1'b0, "single");
  endtask
  task automatic test_burst();
    dly = 3;
    repeat (3) cycle(1'b1, 1'b0, "burst");
    repeat (40) cycle(1'b0, 1'b0, "burst");
  endtask
  task automatic test_overflow();
    dly = 2;
    hold = 1'b1;
    repeat (5) cycle(1'b1, 1'b0, "ovf_fill");
    hold = 1'b0;
    repeat (50) cycle(1'b0, 1'b0, "ovf_drain");
    cycle(1'b0, 1'b1, "ovf_clr");
    repeat (3) cycle(1'b0, 1'b0, "ovf_after");
  endtask
  task automatic test_sat_launch();
    bit hit = 1'b0, p;
    dly = 1;
    hold = 1'b1;
    repeat (4) cycle(1'b1, 1'b0, "sat_fill");
    hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      p = !hit && m_pend == MAX && will_launch(next_acks());
      hit |= p;
      cycle(p, 1'b0, "sat_launch");
    end
    vecs++;
    if (!hit || overflow_o !== 1'b0) begin
      miss++;
      $display("FAIL sat_launch: hit=%b overflow=%b required hit=1 overflow=0", hit, overflow_o);
    end
  endtask
  task automatic test_async_reset();
    dly = 2;
    hold = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, "arst_fill");
    cycle(1'b0, 1'b0, "arst_fill");
    #2;
    arst_i = 1'b1;
    model_reset();
    #1;
    check("arst_async");
    do_reset();
    repeat (10) cycle(1'b0, 1'b0, "arst_quiet");
  endtask
  task automatic test_relaunch();
    dly = 0;
    hold = 1'b1;
    cycle(1'b1, 1'b0, "relaunch");
    cycle(1'b1, 1'b0, "relaunch");
    cycle(1'b1, 1'b0, "relaunch");
    hold = 1'b0;
    ack_tgl_i = m_req;
    repeat (20) cycle(1'b0, 1'b0, "relaunch");
  endtask
  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) begin
        dly = $urandom_range(0, 6);
        hold = $urandom_range(0, 5) == 0;
      end
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, "random");
    end
    hold = 1'b0;
    repeat (60) cycle(1'b0, 1'b0, "random_drain");
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_sat_launch();
    test_async_reset();
    test_relaunch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
